counter_seq_ctrl: RTL and testbench

- Run-control sequencer for the prescaled 8-bit event counter.
- Owns the frequency-divider prescaler and the 8-bit count register.
- Adds start/stop/pause control, up/down direction, parallel load, a programmable terminal value, and done/wrap reporting.
- Sits between the board control inputs (buttons/switches) and the display/LED path that shows the count.

---
 rtl/counter_seq_ctrl_if.sv | 40 ++++
 rtl/counter_seq_ctrl.sv | 175 +++++++++++++++++
 tb/tb_counter_seq_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/counter_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl_if
//   Bundles the board-side command inputs and the display/LED-side status
//   outputs of the run-control sequencer.
//
//   Command group  (master -> slave): start, stop, pause, up_down,
//                                     auto_reload, load, load_val[7:0],
//                                     limit[7:0]
//   Status group   (slave -> master): cont[7:0], tick, wrap, done, busy,
//                                     state[1:0]
//
//   master : board control side (buttons/switches, or a testbench)
//   slave  : the counter_seq_ctrl block
// ---------------------------------------------------------------------------
interface counter_seq_ctrl_if;
    logic       start;
    logic       stop;
    logic       pause;
    logic       up_down;
    logic       auto_reload;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] limit;
    logic [7:0] cont;
    logic       tick;
    logic       wrap;
    logic       done;
    logic       busy;
    logic [1:0] state;

    modport master (
        output start, stop, pause, up_down, auto_reload, load, load_val, limit,
        input  cont, tick, wrap, done, busy, state
    );

    modport slave (
        input  start, stop, pause, up_down, auto_reload, load, load_val, limit,
        output cont, tick, wrap, done, busy, state
    );
endinterface

// File: rtl/counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter_seq_ctrl
//   Run-control sequencer for a prescaled 8-bit event counter. Owns the
//   frequency-divider prescaler and the count register, and adds
//   start/stop/pause control, up/down direction, parallel load, a
//   programmable terminal value and done/wrap reporting.
//
//   Parameters
//     DIV : clock cycles per count tick (>= 2)
//     PW  : prescaler width, 2**PW must exceed DIV
//
//   Ports
//     clk : system clock, rising edge
//     rst : asynchronous, active-high reset
//     bus : counter_seq_ctrl_if.slave
//           in  : start, stop, pause, up_down, auto_reload, load,
//                 load_val[7:0], limit[7:0]
//           out : cont[7:0], tick, wrap, done, busy, state[1:0]
//                 (state: IDLE=00, RUN=01, PAUSE=10, DONE=11)
//
//   All outputs come straight from registers. Command priority in every
//   state is stop > load > start > pause; commands are level-sampled.
// ---------------------------------------------------------------------------
module counter_seq_ctrl #(
    parameter int DIV = 50000000,
    parameter int PW  = 26
) (
    input  logic               clk,
    input  logic               rst,
    counter_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_pre;
    logic [PW-1:0] w_pre_nxt;
    logic [7:0]    r_cont;
    logic [7:0]    w_cont_nxt;
    logic          r_tick;
    logic          r_wrap;
    logic          r_done;
    logic          r_busy;
    logic          w_tick_nxt;
    logic          w_wrap_nxt;
    logic          w_roll;

    // Prescaler rollover: only meaningful while running.
    assign w_roll = (r_state == RUN) && (r_pre == PRE_LAST);

    // -----------------------------------------------------------------------
    // Next-state / next-data logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = r_pre;
        w_cont_nxt  = r_cont;
        w_tick_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;

        if (bus.stop) begin
            w_state_nxt = IDLE;
            w_pre_nxt   = '0;
        end else if (bus.load) begin
            // A load on the rollover cycle suppresses that cycle's step.
            w_cont_nxt = bus.load_val;
            w_pre_nxt  = '0;
            if (r_state == DONE) begin
                w_state_nxt = IDLE;
            end
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = RUN;
                        w_pre_nxt   = '0;
                    end
                end

                RUN: begin
                    // A pause on the rollover cycle still lets the step land;
                    // reaching DONE on that same step takes precedence.
                    if (bus.pause) begin
                        w_state_nxt = PAUSE;
                    end
                    if (w_roll) begin
                        w_pre_nxt  = '0;
                        w_tick_nxt = 1'b1;
                        if (bus.up_down) begin
                            if (r_cont != bus.limit) begin
                                // Above the limit this wraps 255 -> 0 silently.
                                w_cont_nxt = r_cont + 8'd1;
                            end else if (bus.auto_reload) begin
                                w_cont_nxt = 8'd0;
                                w_wrap_nxt = 1'b1;
                            end else begin
                                w_state_nxt = DONE;
                            end
                        end else begin
                            if (r_cont != 8'd0) begin
                                w_cont_nxt = r_cont - 8'd1;
                            end else if (bus.auto_reload) begin
                                w_cont_nxt = bus.limit;
                                w_wrap_nxt = 1'b1;
                            end else begin
                                w_state_nxt = DONE;
                            end
                        end
                    end else begin
                        w_pre_nxt = r_pre + PW'(1);
                    end
                end

                PAUSE: begin
                    // Resume keeps the prescaler phase.
                    if (bus.start) begin
                        w_state_nxt = RUN;
                    end
                end

                DONE: begin
                    if (bus.start) begin
                        w_state_nxt = RUN;
                        w_pre_nxt   = '0;
                        w_cont_nxt  = bus.up_down ? 8'd0 : bus.limit;
                    end
                end

                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State, data and flag registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pre   <= '0;
            r_cont  <= 8'd0;
            r_tick  <= 1'b0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_cont  <= w_cont_nxt;
            r_tick  <= w_tick_nxt;
            r_wrap  <= w_wrap_nxt;
            // Flags follow the next state so they line up with bus.state.
            r_done  <= (w_state_nxt == DONE);
            r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == PAUSE);
        end
    end

    assign bus.cont  = r_cont;
    assign bus.tick  = r_tick;
    assign bus.wrap  = r_wrap;
    assign bus.done  = r_done;
    assign bus.busy  = r_busy;
    assign bus.state = r_state;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_seq_ctrl
//   Table-driven bench for counter_seq_ctrl with DIV=4. Each table row holds
//   the inputs, how many clock edges to hold them, and the outputs expected
//   after the last of those edges. Expected records go through a scoreboard
//   queue. Asynchronous reset is exercised by a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_counter_seq_ctrl;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    typedef struct {
        bit         st, sp, pa, ld, ud, ar;
        logic [7:0] lv, lim;
        int         n;
        logic [7:0] e_cont;
        logic [1:0] e_st;
        bit         e_tick, e_wrap;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    counter_seq_ctrl_if bus ();

    counter_seq_ctrl #(
        .DIV (4),
        .PW  (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    vec_t       tbl[$];
    logic [13:0] sb[$];

    function automatic vec_t mk(bit st, bit sp, bit pa, bit ld, bit ud, bit ar,
                                logic [7:0] lv, logic [7:0] lim, int n,
                                logic [7:0] ec, logic [1:0] es, bit et, bit ew);
        vec_t v;
        v.st = st; v.sp = sp; v.pa = pa; v.ld = ld; v.ud = ud; v.ar = ar;
        v.lv = lv; v.lim = lim; v.n = n;
        v.e_cont = ec; v.e_st = es; v.e_tick = et; v.e_wrap = ew;
        return v;
    endfunction

    // {cont, state, tick, wrap, done, busy}
    function automatic logic [13:0] exp_of(logic [7:0] c, logic [1:0] s, bit t, bit w);
        return {c, s, t, w, (s == S_DONE), (s == S_RUN) || (s == S_PAUSE)};
    endfunction

    function automatic logic [13:0] act_now();
        return {bus.cont, bus.state, bus.tick, bus.wrap, bus.done, bus.busy};
    endfunction

    task automatic check(string name, logic [13:0] act, logic [13:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got cont=%02h state=%0d tick=%b wrap=%b done=%b busy=%b, expected cont=%02h state=%0d tick=%b wrap=%b done=%b busy=%b",
                     name, act[13:6], act[5:4], act[3], act[2], act[1], act[0],
                     exp[13:6], exp[5:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic drive(vec_t v);
        bus.start       = v.st;
        bus.stop        = v.sp;
        bus.pause       = v.pa;
        bus.load        = v.ld;
        bus.up_down     = v.ud;
        bus.auto_reload = v.ar;
        bus.load_val    = v.lv;
        bus.limit       = v.lim;
    endtask

    initial begin
        // --- vector table: st sp pa ld ud ar lv lim n | cont state tick wrap
        // up-count, auto-reload at limit 5
        tbl.push_back(mk(1,0,0,0,1,1,8'h00,8'd5,1,  8'd0,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'h00,8'd5,3,  8'd0,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'h00,8'd5,1,  8'd1,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'h00,8'd5,4,  8'd2,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'h00,8'd5,4,  8'd3,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'h00,8'd5,4,  8'd4,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'h00,8'd5,4,  8'd5,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'h00,8'd5,4,  8'd0,S_RUN,1,1));
        tbl.push_back(mk(0,0,0,0,1,1,8'h00,8'd5,1,  8'd0,S_RUN,0,0));
        // up-count to limit 3 without reload -> DONE, restart
        tbl.push_back(mk(0,1,0,0,1,1,8'h00,8'd5,1,  8'd0,S_IDLE,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,8'h00,8'd3,1,  8'd0,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h00,8'd3,8,  8'd2,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h00,8'd3,4,  8'd3,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h00,8'd3,4,  8'd3,S_DONE,1,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h00,8'd3,1,  8'd3,S_DONE,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,8'h00,8'd3,1,  8'd0,S_RUN,0,0));
        tbl.push_back(mk(0,1,0,0,1,0,8'h00,8'd3,1,  8'd0,S_IDLE,0,0));
        // down-count from loaded 2, reload to 7, then run down to DONE
        tbl.push_back(mk(0,0,0,1,0,1,8'h02,8'd7,1,  8'd2,S_IDLE,0,0));
        tbl.push_back(mk(1,0,0,0,0,1,8'h02,8'd7,1,  8'd2,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,0,1,8'h02,8'd7,4,  8'd1,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,8'h02,8'd7,4,  8'd0,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,0,1,8'h02,8'd7,4,  8'd7,S_RUN,1,1));
        tbl.push_back(mk(0,0,0,0,0,0,8'h02,8'd7,4,  8'd6,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,8'h02,8'd7,24, 8'd0,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,8'h02,8'd7,4,  8'd0,S_DONE,1,0));
        tbl.push_back(mk(1,0,0,0,0,0,8'h02,8'd7,1,  8'd7,S_RUN,0,0));
        // pause two cycles after a tick, hold, resume with prescaler kept
        tbl.push_back(mk(0,0,0,0,1,0,8'h00,8'd200,4, 8'd8,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h00,8'd200,1, 8'd8,S_RUN,0,0));
        tbl.push_back(mk(0,0,1,0,1,0,8'h00,8'd200,1, 8'd8,S_PAUSE,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h00,8'd200,20,8'd8,S_PAUSE,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,8'h00,8'd200,1, 8'd8,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h00,8'd200,1, 8'd8,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h00,8'd200,1, 8'd9,S_RUN,1,0));
        // simultaneous stop+load+start; load on the tick cycle
        tbl.push_back(mk(1,1,0,1,1,0,8'h55,8'd200,1, 8'd9,S_IDLE,0,0));
        tbl.push_back(mk(1,0,0,0,1,0,8'h55,8'd200,1, 8'd9,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h55,8'd200,3, 8'd9,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,1,1,0,8'hAA,8'd200,1, 8'hAA,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'hAA,8'd200,3, 8'hAA,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'hAA,8'd200,1, 8'hAB,S_RUN,1,0));
        // count above limit: 255 -> 0 carries no wrap, then wrap at limit 1
        tbl.push_back(mk(0,0,0,1,1,1,8'hFE,8'd1,1,  8'hFE,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'hFE,8'd1,4,  8'hFF,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'hFE,8'd1,4,  8'h00,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'hFE,8'd1,4,  8'h01,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'hFE,8'd1,4,  8'h00,S_RUN,1,1));
        // load in PAUSE, load in DONE
        tbl.push_back(mk(0,0,0,0,1,1,8'h10,8'd1,1,  8'h00,S_RUN,0,0));
        tbl.push_back(mk(0,0,1,0,1,1,8'h10,8'd1,1,  8'h00,S_PAUSE,0,0));
        tbl.push_back(mk(0,0,0,1,1,1,8'h10,8'd1,1,  8'h10,S_PAUSE,0,0));
        tbl.push_back(mk(1,0,0,0,1,1,8'h10,8'd1,1,  8'h10,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h10,8'h11,4, 8'h11,S_RUN,1,0));
        tbl.push_back(mk(0,0,0,0,1,0,8'h10,8'h11,4, 8'h11,S_DONE,1,0));
        tbl.push_back(mk(0,0,0,1,1,0,8'h33,8'h11,1, 8'h33,S_IDLE,0,0));
        // pause on the tick cycle still steps; start outranks pause
        tbl.push_back(mk(1,0,0,0,1,1,8'h33,8'h40,1, 8'h33,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'h33,8'h40,3, 8'h33,S_RUN,0,0));
        tbl.push_back(mk(0,0,1,0,1,1,8'h33,8'h40,1, 8'h34,S_PAUSE,1,0));
        tbl.push_back(mk(1,0,1,0,1,1,8'h33,8'h40,1, 8'h34,S_RUN,0,0));
        tbl.push_back(mk(0,0,0,0,1,1,8'h33,8'h40,4, 8'h35,S_RUN,1,0));

        // --- reset state
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.load = 0;
        bus.up_down = 0; bus.auto_reload = 0; bus.load_val = 0; bus.limit = 0;
        repeat (2) @(posedge clk);
        #1 check("reset", act_now(), 14'd0);
        @(negedge clk);
        rst = 1'b0;

        // --- table
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            sb.push_back(exp_of(tbl[i].e_cont, tbl[i].e_st, tbl[i].e_tick, tbl[i].e_wrap));
            repeat (tbl[i].n) @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL vec%0d: scoreboard empty", i);
            end else begin
                check($sformatf("vec%0d", i), act_now(), sb.pop_front());
            end
        end

        // --- asynchronous reset mid-run, between edges
        @(negedge clk);
        bus.start = 0; bus.stop = 0; bus.pause = 0; bus.load = 0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst", act_now(), 14'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1 check("post_rst_idle", act_now(), exp_of(8'd0, S_IDLE, 0, 0));
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 check("post_rst_start", act_now(), exp_of(8'd0, S_RUN, 0, 0));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("post_rst_tick", act_now(), exp_of(8'd1, S_RUN, 1, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
